// File: rtl/proc_pkg.sv
// Shared processor constants: instruction field codes, rstatus codes and the
// multiply/divide sequencer state encoding.
package proc_pkg;

  localparam logic [4:0] OPC_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MUL   = 5'b00110;
  localparam logic [4:0] ALU_DIV   = 5'b00111;

  localparam logic [31:0] RSTATUS_MUL_EXC = 32'd4;
  localparam logic [31:0] RSTATUS_DIV_EXC = 32'd5;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_START,
    MD_RUN,
    MD_DONE
  } md_state_t;

  function automatic logic ir_is_mul(input logic [31:0] ir);
    return (ir[31:27] == OPC_RTYPE) && (ir[6:2] == ALU_MUL);
  endfunction

  function automatic logic ir_is_div(input logic [31:0] ir);
    return (ir[31:27] == OPC_RTYPE) && (ir[6:2] == ALU_DIV);
  endfunction

endpackage

// File: rtl/md_cycle_counter.sv
// RUN-cycle counter for the multdiv sequencer; flags the last cycle before
// the sequencer gives up on the unit.
module md_cycle_counter #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tc = (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer sharing the iterative multdiv unit with the pipeline: launches the
// op, stalls PC/FD/DX, bubbles XM, then presents the result for one cycle.
module multdiv_ctrl
  import proc_pkg::*;
#(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_ir,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        md_start_mult,
  output logic        md_start_div,
  output logic        stall,
  output logic        xm_bubble,
  output logic        md_done,
  output logic [31:0] md_out,
  output logic        md_ovf,
  output logic [31:0] md_rstatus,
  output logic        busy
);

  md_state_t   state_reg, state_next;
  logic        op_is_div_reg, op_is_div_next;
  logic [31:0] md_out_reg, md_out_next;
  logic        md_ovf_reg, md_ovf_next;
  logic        is_mul, is_div, is_md;
  logic        cnt_clr, cnt_en, cnt_tc;

  // Only opcode and ALU-op fields matter to the decode.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{dx_ir[26:7], dx_ir[1:0]};

  assign is_mul = ir_is_mul(dx_ir);
  assign is_div = ir_is_div(dx_ir);
  assign is_md  = is_mul | is_div;

  assign cnt_clr = (state_reg == MD_IDLE) && is_md;
  assign cnt_en  = (state_reg == MD_RUN);

  md_cycle_counter #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_cnt (
    .clock(clock),
    .reset(reset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc   (cnt_tc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= MD_IDLE;
      op_is_div_reg <= 1'b0;
      md_out_reg    <= '0;
      md_ovf_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_is_div_reg <= op_is_div_next;
      md_out_reg    <= md_out_next;
      md_ovf_reg    <= md_ovf_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    op_is_div_next = op_is_div_reg;
    md_out_next    = md_out_reg;
    md_ovf_next    = md_ovf_reg;
    case (state_reg)
      MD_IDLE: begin
        if (is_md) begin
          op_is_div_next = is_div;
          state_next     = MD_START;
        end
      end
      MD_START: state_next = MD_RUN;
      MD_RUN: begin
        // A result arriving on the timeout cycle still takes priority.
        if (md_ready) begin
          md_out_next = md_result;
          md_ovf_next = md_exception;
          state_next  = MD_DONE;
        end else if (cnt_tc) begin
          md_out_next = '0;
          md_ovf_next = 1'b1;
          state_next  = MD_DONE;
        end
      end
      MD_DONE: state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  // The IDLE term is combinational from dx_ir, so gate it while reset is held.
  assign stall = (reset && (state_reg == MD_IDLE) && is_md) ||
                 (state_reg == MD_START) || (state_reg == MD_RUN);
  assign xm_bubble     = stall;
  assign md_start_mult = (state_reg == MD_START) && !op_is_div_reg;
  assign md_start_div  = (state_reg == MD_START) && op_is_div_reg;
  assign md_done       = (state_reg == MD_DONE);
  assign busy          = (state_reg != MD_IDLE);
  assign md_out        = md_out_reg;
  assign md_ovf        = md_ovf_reg;
  assign md_rstatus    = md_ovf_reg ? (op_is_div_reg ? RSTATUS_DIV_EXC : RSTATUS_MUL_EXC)
                                    : 32'd0;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: the driver queues expected results, a
// negedge monitor checks each md_done plus stall length and start pulses.
module tb_multdiv_ctrl;

  localparam int TIMEOUT = 40;
  localparam logic [31:0] MUL_IR  = 32'h0044_3018;
  localparam logic [31:0] DIV_IR  = 32'h0044_301C;
  localparam logic [31:0] ADDI_IR = 32'h2840_0005;
  localparam logic [31:0] NOP_IR  = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dx_ir = '0;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0;
  logic        md_ready = 1'b0;
  logic        md_start_mult, md_start_div, stall, xm_bubble, md_done, md_ovf, busy;
  logic [31:0] md_out, md_rstatus;

  multdiv_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
    .clock        (clock),
    .reset        (reset),
    .dx_ir        (dx_ir),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_ready     (md_ready),
    .md_start_mult(md_start_mult),
    .md_start_div (md_start_div),
    .stall        (stall),
    .xm_bubble    (xm_bubble),
    .md_done      (md_done),
    .md_out       (md_out),
    .md_ovf       (md_ovf),
    .md_rstatus   (md_rstatus),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] out;
    logic        ovf;
    logic [31:0] rstatus;
    int          stall_cycles;
    int          n_mult;
    int          n_div;
    int          gap;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input string name, input logic [31:0] out, input logic ovf,
                      input logic [31:0] rst, input int stl, input int nm, input int nd,
                      input int gap);
    exp_t e;
    e.name = name; e.out = out; e.ovf = ovf; e.rstatus = rst;
    e.stall_cycles = stl; e.n_mult = nm; e.n_div = nd; e.gap = gap;
    sb_q.push_back(e);
  endtask

  // Monitor: accumulates per-instruction activity and scores it on md_done.
  initial begin
    int   cyc = 0, last_done = 0, stall_acc = 0, mult_acc = 0, div_acc = 0;
    exp_t e;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        stall_acc = 0; mult_acc = 0; div_acc = 0;
      end else begin
        if (xm_bubble !== stall) begin
          checks++; errors++;
          $display("FAIL bubble_eq_stall: xm_bubble %0b stall %0b", xm_bubble, stall);
        end
        if (stall === 1'b1) stall_acc++;
        if (md_start_mult === 1'b1) mult_acc++;
        if (md_start_div === 1'b1) div_acc++;
        if (md_done === 1'b1) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: md_done 1 expected none, md_out %0h", md_out);
          end else begin
            e = sb_q.pop_front();
            chk({e.name, "_out"}, md_out, e.out);
            chk({e.name, "_ovf"}, {31'b0, md_ovf}, {31'b0, e.ovf});
            chk({e.name, "_rstatus"}, md_rstatus, e.rstatus);
            chk({e.name, "_stall_cycles"}, stall_acc, e.stall_cycles);
            chk({e.name, "_mult_pulses"}, mult_acc, e.n_mult);
            chk({e.name, "_div_pulses"}, div_acc, e.n_div);
            chk({e.name, "_done_stall"}, {31'b0, stall}, 32'd0);
            if (e.gap > 0) chk({e.name, "_done_gap"}, cyc - last_done, e.gap);
            $display("txn %s: out=%0h ovf=%0b rstatus=%0d stall=%0d mult=%0d div=%0d",
                     e.name, md_out, md_ovf, md_rstatus, stall_acc, mult_acc, div_acc);
          end
          last_done = cyc;
          stall_acc = 0; mult_acc = 0; div_acc = 0;
        end
      end
    end
  end

  // Issues one mul/div; md_ready is raised in RUN cycle k_ready (0 = never).
  task automatic run_op(input logic [31:0] ir, input int k_ready, input logic [31:0] res,
                        input logic exc, input logic glitch);
    dx_ir = ir;
    @(posedge clock); #1;
    md_ready = glitch; md_result = 32'h55; md_exception = glitch;
    @(posedge clock); #1;
    for (int k = 1; k <= TIMEOUT; k++) begin
      md_ready     = (k == k_ready);
      md_result    = (k == k_ready) ? res : 32'hBAD0_0000 + k;
      md_exception = (k == k_ready) ? exc : 1'b1;
      @(posedge clock); #1;
      if (k == k_ready) break;
    end
    md_ready = 1'b0; md_exception = 1'b0;
    @(posedge clock); #1;
    dx_ir = NOP_IR;
  endtask

  initial begin
    #12;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_md_out", md_out, 32'd0);
    chk("rst_rstatus", md_rstatus, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock); #1;

    push("mul_3x4", 32'd12, 1'b0, 32'd0, 34, 1, 0, 0);
    run_op(MUL_IR, 32, 32'd12, 1'b0, 1'b0);
    @(negedge clock);
    chk("mul_hold_out", md_out, 32'd12);
    @(posedge clock); #1;

    push("div_7_0", 32'd0, 1'b1, 32'd5, 7, 0, 1, 0);
    run_op(DIV_IR, 5, 32'd0, 1'b1, 1'b0);
    @(posedge clock); #1;

    push("mul_timeout", 32'd0, 1'b1, 32'd4, 2 + TIMEOUT, 1, 0, 0);
    run_op(MUL_IR, 0, 32'd0, 1'b0, 1'b0);
    @(posedge clock); #1;

    push("b2b_mul", 32'd20, 1'b0, 32'd0, 5, 1, 0, 0);
    push("b2b_div", 32'd3, 1'b0, 32'd0, 5, 0, 1, 6);
    run_op(MUL_IR, 3, 32'd20, 1'b0, 1'b0);
    run_op(DIV_IR, 3, 32'd3, 1'b0, 1'b0);
    @(posedge clock); #1;

    push("start_glitch", 32'd99, 1'b0, 32'd0, 6, 1, 0, 0);
    run_op(MUL_IR, 4, 32'd99, 1'b0, 1'b1);
    @(posedge clock); #1;

    // Reset in RUN cycle 10, with DX switching to an addi meanwhile.
    dx_ir = MUL_IR;
    repeat (11) @(posedge clock);
    #3;
    reset = 1'b0; dx_ir = ADDI_IR;
    #1;
    chk("midrun_stall", {31'b0, stall}, 32'd0);
    chk("midrun_bubble", {31'b0, xm_bubble}, 32'd0);
    chk("midrun_busy", {31'b0, busy}, 32'd0);
    chk("midrun_done", {31'b0, md_done}, 32'd0);
    chk("midrun_md_out", md_out, 32'd0);
    chk("midrun_ovf", {31'b0, md_ovf}, 32'd0);
    chk("midrun_rstatus", md_rstatus, 32'd0);
    chk("midrun_starts", {30'b0, md_start_mult, md_start_div}, 32'd0);
    repeat (2) @(posedge clock); #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("addi_stall", {31'b0, stall}, 32'd0);
      chk("addi_starts_busy", {29'b0, md_start_mult, md_start_div, busy}, 32'd0);
    end

    repeat (3) @(posedge clock);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
